// File: rtl/load_store_unit_pkg.sv
// Shared types and constants for the RV32I load/store unit.
package load_store_unit_pkg;

    localparam int DATA_WIDTH = 32;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        RESP = 2'd3
    } lsu_state_t;

endpackage

// File: rtl/load_store_unit_align.sv
// Lane arithmetic for the load/store unit: load extraction/extension,
// sub-word store merge and alignment/legality decode.
module load_store_unit_align
    import load_store_unit_pkg::*;
(
    input  logic [2:0]            i_funct3,
    input  logic                  i_store,
    input  logic [1:0]            i_addr_lo,
    input  logic [DATA_WIDTH-1:0] i_rdata,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    output logic [DATA_WIDTH-1:0] o_load_data,
    output logic [DATA_WIDTH-1:0] o_store_word,
    output logic                  o_misaligned,
    output logic                  o_illegal
);

    function automatic logic [DATA_WIDTH-1:0] sext8(input logic [7:0] b);
        logic signed [7:0] s;
        s = $signed(b);
        return DATA_WIDTH'(s);
    endfunction

    function automatic logic [DATA_WIDTH-1:0] sext16(input logic [15:0] h);
        logic signed [15:0] s;
        s = $signed(h);
        return DATA_WIDTH'(s);
    endfunction

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_byte = 8'(i_rdata >> {i_addr_lo, 3'b000});
    assign w_half = 16'(i_rdata >> {i_addr_lo[1], 4'b0000});

    always_comb begin
        o_load_data = '0;
        case (i_funct3)
            F3_B:    o_load_data = sext8(w_byte);
            F3_H:    o_load_data = sext16(w_half);
            F3_W:    o_load_data = i_rdata;
            F3_BU:   o_load_data = DATA_WIDTH'(w_byte);
            F3_HU:   o_load_data = DATA_WIDTH'(w_half);
            default: o_load_data = '0;
        endcase
    end

    // Sub-word stores keep the untouched lanes of the word read back from memory.
    always_comb begin
        o_store_word = i_wdata;
        case (i_funct3)
            F3_B: begin
                o_store_word = i_rdata;
                o_store_word[{i_addr_lo, 3'b000} +: 8] = i_wdata[7:0];
            end
            F3_H: begin
                o_store_word = i_rdata;
                o_store_word[{i_addr_lo[1], 4'b0000} +: 16] = i_wdata[15:0];
            end
            default: o_store_word = i_wdata;
        endcase
    end

    assign o_illegal    = i_store ? (i_funct3 > F3_W)
                                  : ((i_funct3 == 3'b011) || (i_funct3[2:1] == 2'b11));
    assign o_misaligned = ((i_funct3[1:0] == 2'b01) && i_addr_lo[0])
                       || ((i_funct3[1:0] == 2'b10) && (i_addr_lo != 2'b00));

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit: turns byte-addressed requests into word accesses on a
// memory without byte enables, using read-modify-write for SB/SH.
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int ADDR_WIDTH = 12
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  req_store_i,
    input  logic [2:0]            req_funct3_i,
    input  logic [ADDR_WIDTH-1:0] req_addr_i,
    input  logic [DATA_WIDTH-1:0] req_wdata_i,
    output logic                  resp_valid_o,
    input  logic                  resp_ready_i,
    output logic [DATA_WIDTH-1:0] resp_rdata_o,
    output logic                  resp_err_o,
    output logic                  mem_we_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i
);

    lsu_state_t            r_state;
    lsu_state_t            w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [2:0]            r_funct3;
    logic                  r_store;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [DATA_WIDTH-1:0] r_mem_wdata;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic                  r_err;

    logic                  w_idle;
    logic [2:0]            w_funct3;
    logic                  w_store;
    logic [1:0]            w_addr_lo;
    logic [DATA_WIDTH-1:0] w_wdata;
    logic [DATA_WIDTH-1:0] w_load_data;
    logic [DATA_WIDTH-1:0] w_store_word;
    logic                  w_misaligned;
    logic                  w_illegal;
    logic                  w_err;

    // The aligner decodes the incoming request in IDLE and the latched one afterwards.
    assign w_idle    = (r_state == IDLE);
    assign w_funct3  = w_idle ? req_funct3_i    : r_funct3;
    assign w_store   = w_idle ? req_store_i     : r_store;
    assign w_addr_lo = w_idle ? req_addr_i[1:0] : r_addr[1:0];
    assign w_wdata   = w_idle ? req_wdata_i     : r_wdata;
    assign w_err     = w_misaligned | w_illegal;

    load_store_unit_align u_align (
        .i_funct3     (w_funct3),
        .i_store      (w_store),
        .i_addr_lo    (w_addr_lo),
        .i_rdata      (mem_rdata_i),
        .i_wdata      (w_wdata),
        .o_load_data  (w_load_data),
        .o_store_word (w_store_word),
        .o_misaligned (w_misaligned),
        .o_illegal    (w_illegal)
    );

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        req_ready_o  = 1'b0;
        resp_valid_o = 1'b0;
        mem_we_o     = 1'b0;
        case (r_state)
            IDLE: begin
                req_ready_o = 1'b1;
                if (req_valid_i) begin
                    if (w_err)
                        w_state_nxt = RESP;
                    else if (req_store_i && (req_funct3_i == F3_W))
                        w_state_nxt = WR;
                    else
                        w_state_nxt = RD;
                end
            end
            RD:   w_state_nxt = r_store ? WR : RESP;
            WR: begin
                mem_we_o    = 1'b1;
                w_state_nxt = RESP;
            end
            RESP: begin
                resp_valid_o = 1'b1;
                if (resp_ready_i)
                    w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_addr      <= '0;
            r_funct3    <= '0;
            r_store     <= 1'b0;
            r_wdata     <= '0;
            r_mem_wdata <= '0;
            r_rdata     <= '0;
            r_err       <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (req_valid_i) begin
                        r_addr      <= req_addr_i;
                        r_funct3    <= req_funct3_i;
                        r_store     <= req_store_i;
                        r_wdata     <= req_wdata_i;
                        r_mem_wdata <= req_wdata_i;
                        r_rdata     <= '0;
                        r_err       <= w_err;
                    end
                end
                RD: begin
                    if (r_store)
                        r_mem_wdata <= w_store_word;
                    else
                        r_rdata <= w_load_data;
                end
                default: ;
            endcase
        end
    end

    assign mem_addr_o   = {r_addr[ADDR_WIDTH-1:2], 2'b00};
    assign mem_wdata_o  = r_mem_wdata;
    assign resp_rdata_o = r_rdata;
    assign resp_err_o   = r_err;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: word memory model, per-cycle expectation queue
// built from RV32I load/store rules, plus literal checks of the listed cases.
module tb_load_store_unit;
    import load_store_unit_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_n_i = 1'b0;
    logic        req_valid_i = 1'b0;
    logic        req_ready_o;
    logic        req_store_i = 1'b0;
    logic [2:0]  req_funct3_i = 3'b000;
    logic [11:0] req_addr_i = '0;
    logic [31:0] req_wdata_i = '0;
    logic        resp_valid_o;
    logic        resp_ready_i = 1'b1;
    logic [31:0] resp_rdata_o;
    logic        resp_err_o;
    logic        mem_we_o;
    logic [11:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic [31:0] mem_rdata_i;

    load_store_unit #(.ADDR_WIDTH(12)) dut (
        .clk_i        (clk_i),
        .rst_n_i      (rst_n_i),
        .req_valid_i  (req_valid_i),
        .req_ready_o  (req_ready_o),
        .req_store_i  (req_store_i),
        .req_funct3_i (req_funct3_i),
        .req_addr_i   (req_addr_i),
        .req_wdata_i  (req_wdata_i),
        .resp_valid_o (resp_valid_o),
        .resp_ready_i (resp_ready_i),
        .resp_rdata_o (resp_rdata_o),
        .resp_err_o   (resp_err_o),
        .mem_we_o     (mem_we_o),
        .mem_addr_o   (mem_addr_o),
        .mem_wdata_o  (mem_wdata_o),
        .mem_rdata_i  (mem_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    logic [31:0] mem     [0:1023];
    logic [31:0] ref_mem [0:1023];

    assign mem_rdata_i = mem[mem_addr_o[11:2]];
    always @(posedge clk_i) if (mem_we_o) mem[mem_addr_o[11:2]] = mem_wdata_o;

    typedef struct {
        bit          rdy;
        bit          we;
        logic [11:0] waddr;
        logic [31:0] wdata;
        bit          rv;
        logic [31:0] rdata;
        bit          err;
    } cyc_t;

    cyc_t        exp_q[$];
    int          total = 0;
    int          bad = 0;
    logic [31:0] last_rdata = '0;
    logic        last_err = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic cyc_t mk(input bit rdy, input bit we, input logic [11:0] wa,
                                input logic [31:0] wd, input bit rv, input logic [31:0] rd,
                                input bit err);
        cyc_t c;
        c.rdy = rdy; c.we = we; c.waddr = wa; c.wdata = wd;
        c.rv = rv; c.rdata = rd; c.err = err;
        return c;
    endfunction

    // Expected outcome of one request against the reference memory.
    function automatic void model(input bit st, input logic [2:0] f3, input logic [11:0] a,
                                  input logic [31:0] wd, output bit err,
                                  output logic [31:0] rd, output logic [31:0] ww);
        int          ai, fi, lane_b, lane_h;
        logic [31:0] old, b, h, sb, sh;
        ai = int'(a);
        fi = int'(f3);
        old = ref_mem[a[11:2]];
        lane_b = ai % 4;
        lane_h = (ai / 2) % 2;
        sb = 32'd1 << (8 * lane_b);
        sh = 32'd1 << (16 * lane_h);
        b = (old / sb) % 256;
        h = (old / sh) % 65536;
        err = st ? (fi >= 3) : (fi == 3 || fi >= 6);
        if ((fi % 4 == 1 && ai % 2 != 0) || (fi % 4 == 2 && ai % 4 != 0)) err = 1'b1;
        rd = '0;
        ww = old;
        if (!err) begin
            if (!st) begin
                case (fi)
                    0:       rd = (b >= 128) ? b - 256 : b;
                    1:       rd = (h >= 32768) ? h - 65536 : h;
                    2:       rd = old;
                    4:       rd = b;
                    5:       rd = h;
                    default: rd = '0;
                endcase
            end else begin
                case (fi)
                    0:       ww = old - b * sb + (wd % 256) * sb;
                    1:       ww = old - h * sh + (wd % 65536) * sh;
                    default: ww = wd;
                endcase
            end
        end
    endfunction

    always @(negedge clk_i) begin : compare
        cyc_t e;
        if (rst_n_i) begin
            if (exp_q.size() > 0) e = exp_q.pop_front();
            else e = mk(1'b1, 1'b0, '0, '0, 1'b0, '0, 1'b0);
            chk("req_ready", 32'(req_ready_o), 32'(e.rdy));
            chk("mem_we", 32'(mem_we_o), 32'(e.we));
            if (e.we) begin
                chk("mem_addr", 32'(mem_addr_o), 32'(e.waddr));
                chk("mem_wdata", mem_wdata_o, e.wdata);
            end
            chk("resp_valid", 32'(resp_valid_o), 32'(e.rv));
            if (e.rv) begin
                chk("resp_rdata", resp_rdata_o, e.rdata);
                chk("resp_err", 32'(resp_err_o), 32'(e.err));
                last_rdata = resp_rdata_o;
                last_err   = resp_err_o;
            end
        end
    end

    task automatic set_word(input logic [11:0] a, input logic [31:0] v);
        mem[a[11:2]]     = v;
        ref_mem[a[11:2]] = v;
    endtask

    task automatic do_req(input bit st, input logic [2:0] f3, input logic [11:0] a,
                          input logic [31:0] wd, input int hold);
        bit          err;
        logic [31:0] rd, ww;
        int          n_pre, guard;
        model(st, f3, a, wd, err, rd, ww);
        @(posedge clk_i); #1;
        req_valid_i = 1'b1; req_store_i = st; req_funct3_i = f3;
        req_addr_i = a; req_wdata_i = wd;
        @(posedge clk_i); #1;
        req_valid_i = 1'b0;
        n_pre = 0;
        if (!err) begin
            if (!(st && f3 == F3_W)) begin
                exp_q.push_back(mk(1'b0, 1'b0, '0, '0, 1'b0, '0, 1'b0));
                n_pre++;
            end
            if (st) begin
                exp_q.push_back(mk(1'b0, 1'b1, {a[11:2], 2'b00}, ww, 1'b0, '0, 1'b0));
                n_pre++;
            end
        end
        for (int i = 0; i <= hold; i++) exp_q.push_back(mk(1'b0, 1'b0, '0, '0, 1'b1, rd, err));
        if (hold > 0) begin
            resp_ready_i = 1'b0;
            repeat (n_pre + hold) @(posedge clk_i);
            #1 resp_ready_i = 1'b1;
        end
        guard = 0;
        while (exp_q.size() > 0 && guard < 50) begin
            @(negedge clk_i);
            guard++;
        end
        if (exp_q.size() > 0) begin
            chk("drain_timeout", 32'(exp_q.size()), 32'd0);
            exp_q.delete();
        end
        if (st && !err) ref_mem[a[11:2]] = ww;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_req_ready"}, 32'(req_ready_o), 32'd1);
        chk({tag, "_resp_valid"}, 32'(resp_valid_o), 32'd0);
        chk({tag, "_resp_err"}, 32'(resp_err_o), 32'd0);
        chk({tag, "_resp_rdata"}, resp_rdata_o, 32'd0);
        chk({tag, "_mem_we"}, 32'(mem_we_o), 32'd0);
        chk({tag, "_mem_addr"}, 32'(mem_addr_o), 32'd0);
        chk({tag, "_mem_wdata"}, mem_wdata_o, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 1024; i++) begin
            mem[i] = '0;
            ref_mem[i] = '0;
        end
        repeat (2) @(posedge clk_i);
        #1 chk_reset_vals("reset");
        @(posedge clk_i); #1 rst_n_i = 1'b1;

        set_word(12'h010, 32'hDEADBEEF);
        do_req(1'b0, F3_W, 12'h010, '0, 0);
        chk("lw_data", last_rdata, 32'hDEADBEEF);

        set_word(12'h010, 32'h80FF7F01);
        do_req(1'b0, F3_B, 12'h013, '0, 0);
        chk("lb_data", last_rdata, 32'hFFFFFF80);
        do_req(1'b0, F3_BU, 12'h013, '0, 0);
        chk("lbu_data", last_rdata, 32'h00000080);
        do_req(1'b0, F3_H, 12'h010, '0, 0);
        chk("lh_lo_data", last_rdata, 32'h00007F01);

        set_word(12'h020, 32'h11223344);
        do_req(1'b1, F3_B, 12'h021, 32'h000000AA, 0);
        chk("sb_mem", mem[8], 32'h1122AA44);
        chk("sb_rdata", last_rdata, 32'h0);

        set_word(12'h020, 32'h11223344);
        do_req(1'b1, F3_H, 12'h022, 32'h0000BEEF, 0);
        chk("sh_mem", mem[8], 32'hBEEF3344);
        do_req(1'b0, F3_H, 12'h022, '0, 0);
        chk("lh_data", last_rdata, 32'hFFFFBEEF);
        do_req(1'b0, F3_HU, 12'h022, '0, 0);
        chk("lhu_data", last_rdata, 32'h0000BEEF);

        set_word(12'h004, 32'h0BADF00D);
        do_req(1'b0, F3_W, 12'h005, '0, 0);
        chk("lw_mis_err", 32'(last_err), 32'd1);
        chk("lw_mis_rdata", last_rdata, 32'h0);
        do_req(1'b1, F3_H, 12'h007, 32'h00001234, 0);
        chk("sh_mis_err", 32'(last_err), 32'd1);
        chk("sh_mis_mem", mem[1], 32'h0BADF00D);
        do_req(1'b0, 3'b011, 12'h004, '0, 0);
        chk("ld_ill_err", 32'(last_err), 32'd1);
        do_req(1'b0, 3'b110, 12'h004, '0, 0);
        do_req(1'b1, 3'b100, 12'h004, 32'hFFFFFFFF, 0);
        chk("st_ill_mem", mem[1], 32'h0BADF00D);

        do_req(1'b1, F3_W, 12'h040, 32'h12345678, 0);
        chk("sw_mem", mem[16], 32'h12345678);
        do_req(1'b0, F3_HU, 12'h042, '0, 0);
        chk("lhu_hi_data", last_rdata, 32'h00001234);
        do_req(1'b0, F3_B, 12'h040, '0, 0);
        chk("lb_lane0_data", last_rdata, 32'h00000078);

        set_word(12'h010, 32'hDEADBEEF);
        do_req(1'b0, F3_W, 12'h010, '0, 5);
        chk("hold_data", last_rdata, 32'hDEADBEEF);

        // SB aborted by reset while the write cycle is in progress
        set_word(12'h030, 32'hCAFEF00D);
        @(posedge clk_i); #1;
        req_valid_i = 1'b1; req_store_i = 1'b1; req_funct3_i = F3_B;
        req_addr_i = 12'h031; req_wdata_i = 32'h00000055;
        @(posedge clk_i); #1;
        req_valid_i = 1'b0;
        exp_q.push_back(mk(1'b0, 1'b0, '0, '0, 1'b0, '0, 1'b0));
        @(posedge clk_i); #1;
        chk("wr_before_rst", 32'(mem_we_o), 32'd1);
        rst_n_i = 1'b0;
        #1 chk_reset_vals("async_rst");
        exp_q.delete();
        repeat (2) @(posedge clk_i);
        #1 rst_n_i = 1'b1;
        chk("rst_mem_unchanged", mem[12], 32'hCAFEF00D);

        do_req(1'b0, F3_W, 12'h030, '0, 0);
        chk("post_rst_lw", last_rdata, 32'hCAFEF00D);

        for (int i = 0; i < 24; i++) chk("mem_image", mem[i], ref_mem[i]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
